// File: rtl/bist_response_analyzer.sv
// ---------------------------------------------------------------------------
// bist_response_analyzer
//
// Purpose:
//   Compares memory read data returned during a march test against the
//   expected background bit, counts mismatches and reports a final verdict.
//   Every accepted read pushes its address and expected bit into an
//   RD_LAT-deep tag pipeline. The tag then lines up with rdata when the
//   memory returns it. The compare result is registered, so it is visible
//   RD_LAT+1 cycles after the read strobe.
//
//   Control FSM:
//     IDLE   -> RUN on the first read, or REPORT directly on done.
//     RUN    -> DRAIN on done.
//     DRAIN  -> REPORT when the last in-flight compare retires.
//     REPORT -> holds until clear or reset. result_valid is high here.
//   Reads seen in DRAIN or REPORT are dropped.
//
// Configuration macro:
//   BIST_FAIL_LOG_EN - when defined, the address tag and rdata of the first
//                      mismatch are captured on fail_addr / fail_data. When
//                      undefined, both outputs are tied to zero and no
//                      capture registers exist.
//
// Parameters:
//   DATA_W  memory word width
//   ADDR_W  memory address width
//   RD_LAT  memory read latency in cycles (1..4)
//   ERR_W   error counter width
//
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous active-low reset
//   clear         synchronous clear of results and in-flight reads
//   read          read strobe from the march controller
//   out           expected background bit (replicated to DATA_W)
//   addr          address of the current read
//   done          march-complete pulse
//   rdata         memory read data, valid RD_LAT cycles after read
//   is_equal      registered result of the last completed compare
//   cmp_valid     one-cycle pulse per completed compare
//   fail          sticky mismatch flag
//   err_cnt       saturating mismatch count
//   result_valid  results are final (REPORT state)
//   fail_addr     address of the first mismatch (macro dependent)
//   fail_data     rdata of the first mismatch (macro dependent)
// ---------------------------------------------------------------------------
module bist_response_analyzer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              read,
  input  logic              out,
  input  logic [ADDR_W-1:0] addr,
  input  logic              done,
  input  logic [DATA_W-1:0] rdata,
  output logic              is_equal,
  output logic              cmp_valid,
  output logic              fail,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              result_valid,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  // Reject unsupported latencies at elaboration time.
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("bist_response_analyzer: RD_LAT must be in 1..4");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  // The read is entered into the tag pipeline this cycle.
  logic accept;

  // Flattened views of the tag pipeline, one entry per stage.
  logic [RD_LAT-1:0] vld_vec;
  logic [RD_LAT-1:0] exp_vec;
  logic [ADDR_W-1:0] addr_vec [RD_LAT];

  // -------------------------------------------------------------------------
  // Tag pipeline. Stage 0 takes the accepted read. Each later stage takes
  // the stage before it. The last stage lines up with rdata.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tag
    logic              vld_reg;
    logic              exp_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              vld_in;
    logic              exp_in;
    logic [ADDR_W-1:0] addr_in;

    if (gi == 0) begin : g_head
      assign vld_in  = accept;
      assign exp_in  = out;
      assign addr_in = addr;
    end else begin : g_link
      assign vld_in  = vld_vec[gi-1];
      assign exp_in  = exp_vec[gi-1];
      assign addr_in = addr_vec[gi-1];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_reg  <= 1'b0;
        exp_reg  <= 1'b0;
        addr_reg <= '0;
      end else if (clear) begin
        vld_reg  <= 1'b0;
        exp_reg  <= 1'b0;
        addr_reg <= '0;
      end else begin
        vld_reg  <= vld_in;
        exp_reg  <= exp_in;
        addr_reg <= addr_in;
      end
    end

    assign vld_vec[gi]  = vld_reg;
    assign exp_vec[gi]  = exp_reg;
    assign addr_vec[gi] = addr_reg;
  end

  // -------------------------------------------------------------------------
  // Compare stage: the tail of the tag pipeline meets rdata.
  // -------------------------------------------------------------------------
  logic              tail_vld;
  logic              tail_exp;
  logic [ADDR_W-1:0] tail_addr;
  logic [DATA_W-1:0] expected_word;
  logic              match;
  logic              mismatch;

  assign tail_vld      = vld_vec[RD_LAT-1];
  assign tail_exp      = exp_vec[RD_LAT-1];
  assign tail_addr     = addr_vec[RD_LAT-1];
  assign expected_word = {DATA_W{tail_exp}};
  assign match         = (rdata == expected_word);
  assign mismatch      = tail_vld && !match;

  // A read is still in flight after this edge when any stage other than
  // the tail is occupied. The tail entry retires at this edge.
  logic busy_after;

  if (RD_LAT == 1) begin : g_busy_single
    assign busy_after = 1'b0;
  end else begin : g_busy_multi
    assign busy_after = |vld_vec[RD_LAT-2:0];
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    if (clear) begin
      // A read in the same cycle as clear is discarded.
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE: begin
          accept = read;
          if (done) begin
            // When read and done arrive together, the read still has to
            // retire before REPORT.
            state_next = read ? DRAIN : REPORT;
          end else if (read) begin
            state_next = RUN;
          end
        end
        RUN: begin
          accept = read;
          if (done) begin
            state_next = DRAIN;
          end
        end
        DRAIN: begin
          // Enter REPORT on the same edge that retires the last compare.
          // The final counts and result_valid then appear together.
          if (!busy_after) begin
            state_next = REPORT;
          end
        end
        REPORT: begin
          state_next = REPORT;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Result registers
  // -------------------------------------------------------------------------
  logic             is_equal_reg;
  logic             cmp_valid_reg;
  logic             fail_reg;
  logic [ERR_W-1:0] err_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_equal_reg  <= 1'b1;
      cmp_valid_reg <= 1'b0;
      fail_reg      <= 1'b0;
      err_cnt_reg   <= '0;
    end else if (clear) begin
      is_equal_reg  <= 1'b1;
      cmp_valid_reg <= 1'b0;
      fail_reg      <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      cmp_valid_reg <= tail_vld;
      if (tail_vld) begin
        is_equal_reg <= match;
      end
      if (mismatch) begin
        fail_reg <= 1'b1;
        // Saturate rather than wrap: the count never goes back to zero.
        if (err_cnt_reg != {ERR_W{1'b1}}) begin
          err_cnt_reg <= err_cnt_reg + ERR_W'(1);
        end
      end
    end
  end

  assign is_equal     = is_equal_reg;
  assign cmp_valid    = cmp_valid_reg;
  assign fail         = fail_reg;
  assign err_cnt      = err_cnt_reg;
  assign result_valid = (state_reg == REPORT);

  // -------------------------------------------------------------------------
  // First-failure log
  // -------------------------------------------------------------------------
`ifdef BIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] fail_addr_reg;
  logic [DATA_W-1:0] fail_data_reg;

  // fail_reg is still low on the edge of the first mismatch. Later
  // mismatches leave the capture unchanged until clear or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_addr_reg <= '0;
      fail_data_reg <= '0;
    end else if (clear) begin
      fail_addr_reg <= '0;
      fail_data_reg <= '0;
    end else if (mismatch && !fail_reg) begin
      fail_addr_reg <= tail_addr;
      fail_data_reg <= rdata;
    end
  end

  assign fail_addr = fail_addr_reg;
  assign fail_data = fail_data_reg;
`else
  assign fail_addr = '0;
  assign fail_data = '0;

  // The address tag has no consumer without the log. Synthesis trims it.
  logic unused_tail_addr;
  assign unused_tail_addr = ^tail_addr;
`endif

endmodule

// File: tb/tb_bist_response_analyzer.sv
// ---------------------------------------------------------------------------
// tb_bist_response_analyzer
//
// Purpose:
//   Self-checking bench for bist_response_analyzer with default parameters.
//   Directed vectors come from a table and carry hand-derived expectations.
//   Hand-written sequences cover saturation and asynchronous reset.
//   Randomized runs follow. A timestamp-based reference model checks every
//   cycle.
//
// Reference model:
//   Each accepted read is queued with the cycle in which its compare
//   becomes visible (issue + RD_LAT + 1). The report cycle is derived from
//   the moment done is seen and the last queued visibility time.
// ---------------------------------------------------------------------------
module tb_bist_response_analyzer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int RD_LAT = 1;
  localparam int ERR_W  = 8;

`ifdef BIST_FAIL_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clear = 1'b0;
  logic              read = 1'b0;
  logic              out = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic              done = 1'b0;
  logic [DATA_W-1:0] rdata = '0;
  logic              is_equal;
  logic              cmp_valid;
  logic              fail;
  logic [ERR_W-1:0]  err_cnt;
  logic              result_valid;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;

  bist_response_analyzer #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT),
    .ERR_W (ERR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .read        (read),
    .out         (out),
    .addr        (addr),
    .done        (done),
    .rdata       (rdata),
    .is_equal    (is_equal),
    .cmp_valid   (cmp_valid),
    .fail        (fail),
    .err_cnt     (err_cnt),
    .result_valid(result_valid),
    .fail_addr   (fail_addr),
    .fail_data   (fail_data)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  // ---------------- reference model ----------------
  typedef struct {
    int          vis;
    logic [3:0]  a;
    logic        e;
    logic [7:0]  d;
  } rd_t;

  rd_t        pend[$];
  logic       m_cv, m_eq, m_fail, m_rv;
  logic [7:0] m_err;
  logic [3:0] m_fa;
  logic [7:0] m_fd;
  bit         m_done_seen, m_started;
  int         m_report_at;

  function automatic void model_reset();
    pend.delete();
    m_cv = 1'b0; m_eq = 1'b1; m_fail = 1'b0; m_rv = 1'b0;
    m_err = 8'h00; m_fa = 4'h0; m_fd = 8'h00;
    m_done_seen = 1'b0; m_started = 1'b0; m_report_at = -1;
  endfunction

  function automatic void model_step(bit rd, bit o, logic [3:0] a, logic [7:0] d, bit dn, bit clr);
    rd_t r;
    bit  was_started, acc;
    int  last;
    if (clr) begin
      model_reset();
      return;
    end
    m_cv = 1'b0;
    if (pend.size() > 0 && pend[0].vis == cyc + 1) begin
      r = pend.pop_front();
      m_cv = 1'b1;
      m_eq = (r.d == {8{r.e}});
      if (!m_eq) begin
        if (!m_fail) begin
          m_fa = r.a;
          m_fd = r.d;
        end
        m_fail = 1'b1;
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
      end
    end
    was_started = m_started;
    acc = rd && !m_done_seen;
    if (acc) begin
      r.vis = cyc + 1 + RD_LAT; r.a = a; r.e = o; r.d = d;
      pend.push_back(r);
      m_started = 1'b1;
    end
    if (dn && !m_done_seen) begin
      m_done_seen = 1'b1;
      if (!was_started && !acc) begin
        m_report_at = cyc + 1;
      end else begin
        last = cyc + 2;
        if (pend.size() > 0 && pend[$].vis > last) last = pend[$].vis;
        m_report_at = last;
      end
    end
    m_rv = (m_report_at >= 0) && (cyc + 1 >= m_report_at);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    check("model.cmp_valid",    32'(cmp_valid),    32'(m_cv));
    check("model.is_equal",     32'(is_equal),     32'(m_eq));
    check("model.fail",         32'(fail),         32'(m_fail));
    check("model.err_cnt",      32'(err_cnt),      32'(m_err));
    check("model.result_valid", 32'(result_valid), 32'(m_rv));
    check("model.fail_addr",    32'(fail_addr),    LOG_EN ? 32'(m_fa) : 32'd0);
    check("model.fail_data",    32'(fail_data),    LOG_EN ? 32'(m_fd) : 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".cmp_valid"},    32'(cmp_valid),    32'd0);
    check({tag, ".is_equal"},     32'(is_equal),     32'd1);
    check({tag, ".fail"},         32'(fail),         32'd0);
    check({tag, ".err_cnt"},      32'(err_cnt),      32'd0);
    check({tag, ".result_valid"}, 32'(result_valid), 32'd0);
    check({tag, ".fail_addr"},    32'(fail_addr),    32'd0);
    check({tag, ".fail_data"},    32'(fail_data),    32'd0);
  endtask

  // One clock: drive inputs, supply memory data for the read issued RD_LAT
  // cycles ago (random garbage otherwise), step the model, compare.
  task automatic tick(input bit rd, input bit o, input logic [3:0] a, input logic [7:0] d,
                      input bit dn, input bit clr);
    read = rd; out = o; addr = a; done = dn; clear = clr;
    if (pend.size() > 0 && pend[0].vis == cyc + 1) rdata = pend[0].d;
    else rdata = 8'($urandom);
    @(posedge clk);
    #1;
    model_step(rd, o, a, d, dn, clr);
    cyc++;
    check_model();
    read = 1'b0; done = 1'b0; clear = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         rd;
    bit         o;
    logic [3:0] a;
    logic [7:0] d;
    bit         dn;
    bit         clr;
    bit         cv;
    bit         eq;
    bit         fl;
    logic [7:0] err;
    bit         rv;
  } vec_t;

  localparam int NVEC = 20;
  vec_t tbl[NVEC];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         rr, oo, dd, cc;
    logic [3:0] aa;
    logic [7:0] ww;
    int         n;

    //            rd o  a      d      dn clr  cv eq fl err    rv
    tbl[0]  = '{1, 0, 4'd3, 8'h00, 0, 0,   0, 1, 0, 8'd0, 0};
    tbl[1]  = '{0, 0, 4'd0, 8'h00, 0, 0,   1, 1, 0, 8'd0, 0};
    tbl[2]  = '{0, 0, 4'd0, 8'h00, 0, 0,   0, 1, 0, 8'd0, 0};
    tbl[3]  = '{1, 1, 4'd2, 8'hFF, 0, 0,   0, 1, 0, 8'd0, 0};
    tbl[4]  = '{1, 1, 4'd5, 8'hFE, 0, 0,   1, 1, 0, 8'd0, 0};
    tbl[5]  = '{1, 1, 4'd6, 8'h7F, 0, 0,   1, 0, 1, 8'd1, 0};
    tbl[6]  = '{0, 0, 4'd0, 8'h00, 0, 0,   1, 0, 1, 8'd2, 0};
    tbl[7]  = '{0, 0, 4'd0, 8'h00, 0, 0,   0, 0, 1, 8'd2, 0};
    tbl[8]  = '{1, 0, 4'd1, 8'h00, 1, 0,   0, 0, 1, 8'd2, 0};
    tbl[9]  = '{0, 0, 4'd0, 8'h00, 0, 0,   1, 1, 1, 8'd2, 1};
    tbl[10] = '{1, 1, 4'd7, 8'h00, 0, 0,   0, 1, 1, 8'd2, 1};
    tbl[11] = '{0, 0, 4'd0, 8'h00, 0, 0,   0, 1, 1, 8'd2, 1};
    tbl[12] = '{0, 0, 4'd0, 8'h00, 0, 1,   0, 1, 0, 8'd0, 0};
    tbl[13] = '{1, 1, 4'd4, 8'h00, 0, 0,   0, 1, 0, 8'd0, 0};
    tbl[14] = '{0, 0, 4'd0, 8'h00, 0, 1,   0, 1, 0, 8'd0, 0};
    tbl[15] = '{0, 0, 4'd0, 8'h00, 0, 0,   0, 1, 0, 8'd0, 0};
    tbl[16] = '{0, 0, 4'd0, 8'h00, 1, 0,   0, 1, 0, 8'd0, 1};
    tbl[17] = '{0, 0, 4'd0, 8'h00, 0, 1,   0, 1, 0, 8'd0, 0};
    tbl[18] = '{1, 1, 4'd9, 8'h00, 0, 1,   0, 1, 0, 8'd0, 0};
    tbl[19] = '{0, 0, 4'd0, 8'h00, 0, 0,   0, 1, 0, 8'd0, 0};

    // Power-on reset: rst is low from time zero; the first edge resets.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    $display("[TB] power-on reset: cmp_valid=%0b is_equal=%0b fail=%0b err_cnt=%0d result_valid=%0b",
             cmp_valid, is_equal, fail, err_cnt, result_valid);
    rst = 1'b1;

    // Directed table.
    for (int i = 0; i < NVEC; i++) begin
      tick(tbl[i].rd, tbl[i].o, tbl[i].a, tbl[i].d, tbl[i].dn, tbl[i].clr);
      check($sformatf("vec%0d.cmp_valid", i),    32'(cmp_valid),    32'(tbl[i].cv));
      check($sformatf("vec%0d.is_equal", i),     32'(is_equal),     32'(tbl[i].eq));
      check($sformatf("vec%0d.fail", i),         32'(fail),         32'(tbl[i].fl));
      check($sformatf("vec%0d.err_cnt", i),      32'(err_cnt),      32'(tbl[i].err));
      check($sformatf("vec%0d.result_valid", i), 32'(result_valid), 32'(tbl[i].rv));
      if (i == 7) begin
        check("vec7.fail_addr", 32'(fail_addr), LOG_EN ? 32'd5 : 32'd0);
        check("vec7.fail_data", 32'(fail_data), LOG_EN ? 32'hFE : 32'd0);
      end
      if (i == 12) begin
        check("vec12.fail_addr", 32'(fail_addr), 32'd0);
        check("vec12.fail_data", 32'(fail_data), 32'd0);
      end
      $display("[TB] vec %0d: rd=%0b out=%0b addr=%0d data=%02h done=%0b clear=%0b -> cmp_valid=%0b is_equal=%0b fail=%0b err_cnt=%0d result_valid=%0b",
               i, tbl[i].rd, tbl[i].o, tbl[i].a, tbl[i].d, tbl[i].dn, tbl[i].clr,
               cmp_valid, is_equal, fail, err_cnt, result_valid);
    end

    // Saturation: 300 back-to-back mismatching reads.
    tick(0, 0, 4'd0, 8'h00, 0, 1);
    for (int i = 0; i < 300; i++) begin
      tick(1, 0, 4'($urandom), 8'($urandom_range(1, 255)), 0, 0);
    end
    tick(0, 0, 4'd0, 8'h00, 0, 0);
    check("sat.err_cnt", 32'(err_cnt), 32'hFF);
    check("sat.fail",    32'(fail),    32'd1);
    tick(0, 0, 4'd0, 8'h00, 1, 0);
    repeat (3) tick(0, 0, 4'd0, 8'h00, 0, 0);
    check("sat.err_cnt_held", 32'(err_cnt),      32'hFF);
    check("sat.result_valid", 32'(result_valid), 32'd1);
    $display("[TB] saturation: 300 mismatching reads -> err_cnt=%02h fail=%0b result_valid=%0b",
             err_cnt, fail, result_valid);

    // Asynchronous reset mid-RUN with fail set and a read in flight.
    tick(0, 0, 4'd0, 8'h00, 0, 1);
    tick(1, 1, 4'd3, 8'h0F, 0, 0);
    tick(0, 0, 4'd0, 8'h00, 0, 0);
    check("rst.fail_before", 32'(fail), 32'd1);
    tick(1, 0, 4'd8, 8'hAA, 0, 0);
    rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    check_reset_values("rst_held");
    rst = 1'b1;
    tick(1, 1, 4'd11, 8'hFF, 0, 0);
    tick(1, 1, 4'd12, 8'hF7, 1, 0);
    tick(0, 0, 4'd0, 8'h00, 0, 0);
    check("rst.rerun_result_valid", 32'(result_valid), 32'd1);
    check("rst.rerun_err_cnt",      32'(err_cnt),      32'd1);
    check("rst.rerun_fail_addr",    32'(fail_addr),    LOG_EN ? 32'd12 : 32'd0);
    $display("[TB] reset mid-run then rerun: err_cnt=%0d fail=%0b result_valid=%0b fail_addr=%0d fail_data=%02h",
             err_cnt, fail, result_valid, fail_addr, fail_data);

    // Randomized runs against the model.
    for (int run = 0; run < 8; run++) begin
      tick(0, 0, 4'd0, 8'h00, 0, 1);
      n = $urandom_range(10, 40);
      for (int i = 0; i < n; i++) begin
        rr = ($urandom_range(0, 99) < 70);
        oo = 1'($urandom);
        aa = 4'($urandom);
        ww = ($urandom_range(0, 1) == 0) ? {8{oo}} : 8'($urandom);
        dd = (i == n - 1);
        cc = ($urandom_range(0, 199) == 0);
        tick(rr, oo, aa, ww, dd, cc);
      end
      for (int i = 0; i < RD_LAT + 5; i++) begin
        tick(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom), 0, 0);
      end
      $display("[TB] random run %0d: %0d cycles -> err_cnt=%0d fail=%0b result_valid=%0b",
               run, n, err_cnt, fail, result_valid);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
